cgra_table_load_sequencer: RTL and testbench

- Controller in front of the CGRA runtime instruction table (AXI read master plus per-column PC logic).
- On a single start request it issues one table-load transfer per column, each with a strided HBM byte offset, and waits for each transfer's ctrl_done.
- It then loads every column PC with a common start value and steps all PCs in lockstep for a programmed number of instruction cycles.
- It raises done when finished; the host or the kernel top only pulses start.

---
 rtl/cgra_table_load_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_cgra_table_load_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cgra_table_load_sequencer.sv
// cgra_table_load_sequencer
//
// Front-end controller for the CGRA runtime instruction table. One start
// request loads each column's instruction image from HBM (one table transfer
// per column at a strided byte offset), then loads every column PC with a
// common start value and steps all PCs in lockstep for run_len increments.
//
// Ports
//   aclk, aresetn            clock, asynchronous active-low reset
//   start, skip_load         job request (accepted only in IDLE) and load bypass
//   base_addr, col_stride    column 0 byte offset and per-column byte distance
//   col_xfer_bytes           bytes per column transfer
//   start_pc, run_len        PC start value and number of PC increments
//   stall                    holds the PCs while running
//   busy, done               job in progress / one-cycle completion pulse
//   cur_col, run_count       column being loaded / increments issued so far
//   ctrl_start, ctrl_addr_offset, ctrl_xfer_size_in_bytes, ctrl_done
//                            table transfer request and completion
//   clken_PC, load_PC, incr_PC, load_value_PC
//                            per-column PC controls
//   dbg_state                current sequencer state
//
// Handshake: ctrl_start is a single-cycle request; ctrl_addr_offset and
// ctrl_xfer_size_in_bytes are valid while it is high and the table answers
// with a single-cycle ctrl_done. No back-pressure exists on either side; a
// ctrl_done is only consumed while waiting for an outstanding transfer.
//
// All outputs are registered: each output register is written on the edge
// that enters the state it belongs to.

module cgra_table_load_sequencer #(
  parameter int NUM_COL    = 2,
  parameter int ADDR_WIDTH = 64,
  parameter int PC_WIDTH   = 12,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          start,
  input  logic                          skip_load,
  input  logic [ADDR_WIDTH-1:0]         base_addr,
  input  logic [ADDR_WIDTH-1:0]         col_stride,
  input  logic [ADDR_WIDTH-1:0]         col_xfer_bytes,
  input  logic [PC_WIDTH-1:0]           start_pc,
  input  logic [CNT_WIDTH-1:0]          run_len,
  input  logic                          stall,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(NUM_COL):0]      cur_col,
  output logic [CNT_WIDTH-1:0]          run_count,
  output logic                          ctrl_start,
  output logic [ADDR_WIDTH-1:0]         ctrl_addr_offset,
  output logic [ADDR_WIDTH-1:0]         ctrl_xfer_size_in_bytes,
  input  logic                          ctrl_done,
  output logic [NUM_COL-1:0]            clken_PC,
  output logic [NUM_COL-1:0]            load_PC,
  output logic [NUM_COL-1:0]            incr_PC,
  output logic [NUM_COL*PC_WIDTH-1:0]   load_value_PC,
  output logic [2:0]                    dbg_state
);

  localparam int COL_W = $clog2(NUM_COL) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOAD_REQ,
    S_LOAD_WAIT,
    S_PC_INIT,
    S_RUN,
    S_DONE
  } state_t;

  state_t                      state_q;
  logic                        busy_q, done_q, ctrl_start_q;
  logic [COL_W-1:0]            cur_col_q;
  logic [CNT_WIDTH-1:0]        run_count_q, left_q;
  logic [ADDR_WIDTH-1:0]       ctrl_addr_q, ctrl_size_q;
  logic [NUM_COL-1:0]          clken_q, load_q, incr_q;
  logic [NUM_COL*PC_WIDTH-1:0] load_value_q;

  // Operands latched when the job is accepted.
  logic                        skip_q;
  logic [ADDR_WIDTH-1:0]       stride_q, xfer_q;
  logic [PC_WIDTH-1:0]         start_pc_q;
  logic [CNT_WIDTH-1:0]        run_len_q;

  // Running column offset: base + col*stride is built by repeated addition,
  // which wraps modulo 2^ADDR_WIDTH exactly like the product form.
  logic [ADDR_WIDTH-1:0]       next_off_q, next_off_d;

  logic                        step_d;
  logic [CNT_WIDTH-1:0]        first_left_d, left_d, count_d;

  assign next_off_d   = next_off_q + stride_q;
  assign step_d       = ~stall;
  assign first_left_d = run_len_q - CNT_WIDTH'(step_d);
  assign left_d       = left_q - CNT_WIDTH'(step_d);
  assign count_d      = run_count_q + CNT_WIDTH'(step_d);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ctrl_start_q <= 1'b0;
      cur_col_q    <= '0;
      run_count_q  <= '0;
      left_q       <= '0;
      ctrl_addr_q  <= '0;
      ctrl_size_q  <= '0;
      clken_q      <= '0;
      load_q       <= '0;
      incr_q       <= '0;
      load_value_q <= '0;
      skip_q       <= 1'b0;
      stride_q     <= '0;
      xfer_q       <= '0;
      start_pc_q   <= '0;
      run_len_q    <= '0;
      next_off_q   <= '0;
    end else begin
      // Pulse-type outputs default low each cycle.
      done_q       <= 1'b0;
      ctrl_start_q <= 1'b0;
      load_q       <= '0;
      incr_q       <= '0;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            skip_q      <= skip_load;
            stride_q    <= col_stride;
            xfer_q      <= col_xfer_bytes;
            start_pc_q  <= start_pc;
            run_len_q   <= run_len;
            next_off_q  <= base_addr;
            cur_col_q   <= '0;
            run_count_q <= '0;
            busy_q      <= 1'b1;
            state_q     <= S_SETUP;
          end
        end

        // One cycle so that the first request and the PC load are driven
        // purely from latched operands.
        S_SETUP: begin
          if (skip_q) begin
            clken_q      <= '1;
            load_q       <= '1;
            load_value_q <= {NUM_COL{start_pc_q}};
            state_q      <= S_PC_INIT;
          end else begin
            ctrl_start_q <= 1'b1;
            ctrl_addr_q  <= next_off_q;
            ctrl_size_q  <= xfer_q;
            state_q      <= S_LOAD_REQ;
          end
        end

        S_LOAD_REQ: begin
          next_off_q <= next_off_d;
          state_q    <= S_LOAD_WAIT;
        end

        S_LOAD_WAIT: begin
          if (ctrl_done) begin
            if (cur_col_q == COL_W'(NUM_COL - 1)) begin
              clken_q      <= '1;
              load_q       <= '1;
              load_value_q <= {NUM_COL{start_pc_q}};
              state_q      <= S_PC_INIT;
            end else begin
              cur_col_q    <= cur_col_q + COL_W'(1);
              ctrl_start_q <= 1'b1;
              ctrl_addr_q  <= next_off_q;
              ctrl_size_q  <= xfer_q;
              state_q      <= S_LOAD_REQ;
            end
          end
        end

        S_PC_INIT: begin
          if (run_len_q == '0) begin
            clken_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            incr_q      <= {NUM_COL{step_d}};
            run_count_q <= count_d;
            left_q      <= first_left_d;
            state_q     <= S_RUN;
          end
        end

        // left_q counts increments still owed; a stalled cycle issues none,
        // so the total always equals run_len.
        S_RUN: begin
          if (left_q == '0) begin
            clken_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            incr_q      <= {NUM_COL{step_d}};
            run_count_q <= count_d;
            left_q      <= left_d;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy                    = busy_q;
  assign done                    = done_q;
  assign cur_col                 = cur_col_q;
  assign run_count               = run_count_q;
  assign ctrl_start              = ctrl_start_q;
  assign ctrl_addr_offset        = ctrl_addr_q;
  assign ctrl_xfer_size_in_bytes = ctrl_size_q;
  assign clken_PC                = clken_q;
  assign load_PC                 = load_q;
  assign incr_PC                 = incr_q;
  assign load_value_PC           = load_value_q;
  assign dbg_state               = state_q;

endmodule

// File: tb/tb_cgra_table_load_sequencer.sv
module tb_cgra_table_load_sequencer;

  localparam int NC = 2;
  localparam int AW = 64;
  localparam int PW = 12;
  localparam int CW = 32;

  logic              clk;
  logic              rst_n;
  logic              start, skip_load, stall, ctrl_done;
  logic [AW-1:0]     base_addr, col_stride, col_xfer_bytes;
  logic [PW-1:0]     start_pc;
  logic [CW-1:0]     run_len;
  logic              busy, done, ctrl_start;
  logic [$clog2(NC):0] cur_col;
  logic [CW-1:0]     run_count;
  logic [AW-1:0]     ctrl_addr_offset, ctrl_xfer_size_in_bytes;
  logic [NC-1:0]     clken_PC, load_PC, incr_PC;
  logic [NC*PW-1:0]  load_value_PC;
  logic [2:0]        dbg_state;

  int vectors     = 0;
  int miscompares = 0;

  // Scoreboard: expected transfer offsets, in issue order.
  logic [AW-1:0] exp_q[$];

  cgra_table_load_sequencer #(
    .NUM_COL(NC), .ADDR_WIDTH(AW), .PC_WIDTH(PW), .CNT_WIDTH(CW)
  ) dut (
    .aclk(clk), .aresetn(rst_n), .start(start), .skip_load(skip_load),
    .base_addr(base_addr), .col_stride(col_stride), .col_xfer_bytes(col_xfer_bytes),
    .start_pc(start_pc), .run_len(run_len), .stall(stall),
    .busy(busy), .done(done), .cur_col(cur_col), .run_count(run_count),
    .ctrl_start(ctrl_start), .ctrl_addr_offset(ctrl_addr_offset),
    .ctrl_xfer_size_in_bytes(ctrl_xfer_size_in_bytes), .ctrl_done(ctrl_done),
    .clken_PC(clken_PC), .load_PC(load_PC), .incr_PC(incr_PC),
    .load_value_PC(load_value_PC), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NC*PW-1:0] replicate_pc(input logic [PW-1:0] pc);
    logic [NC*PW-1:0] v;
    v = '0;
    for (int c = 0; c < NC; c++) v[c*PW +: PW] = pc;
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_cstart"}, ctrl_start, 0);
    check({tag, "_clken"}, clken_PC, 0);
    check({tag, "_load"},  load_PC, 0);
    check({tag, "_incr"},  incr_PC, 0);
    check({tag, "_off"},   ctrl_addr_offset, 0);
    check({tag, "_size"},  ctrl_xfer_size_in_bytes, 0);
    check({tag, "_lval"},  load_value_PC, 0);
    check({tag, "_col"},   cur_col, 0);
    check({tag, "_rcnt"},  run_count, 0);
  endtask

  // stall mode: 0 none, 1 random (bounded count), 2 RUN cycles 2 and 3
  function automatic logic pick_stall(input int mode, input int idx, input int used);
    if (mode == 1) return ($urandom_range(0, 2) == 0) && (used < 8);
    if (mode == 2) return (idx == 2) || (idx == 3);
    return 1'b0;
  endfunction

  // ---------------- driver: one complete job ----------------
  task automatic run_job(input logic skip, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                         input logic [AW-1:0] xfer, input logic [PW-1:0] pc, input logic [CW-1:0] len,
                         input int stall_mode, input int done_dly, input bit poke_start,
                         input int exp_run_cycles);
    logic [AW-1:0] exp_off;
    logic          prev_stall;
    int            waited, issued, run_cycles, stalls_used, d;

    exp_q.delete();
    if (!skip)
      for (int c = 0; c < NC; c++) exp_q.push_back(base + AW'(c) * stride);

    @(negedge clk);
    start = 1'b1; skip_load = skip; base_addr = base; col_stride = stride;
    col_xfer_bytes = xfer; start_pc = pc; run_len = len; stall = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("cur_col_cleared", cur_col, 0);
    check("run_count_cleared", run_count, 0);
    check("no_cstart_setup", ctrl_start, 0);
    // Inputs are only meaningful at acceptance; scramble them afterwards.
    base_addr = {$urandom, $urandom}; col_stride = {$urandom, $urandom};
    col_xfer_bytes = {$urandom, $urandom}; start_pc = PW'($urandom);
    run_len = $urandom; skip_load = $urandom_range(0, 1);

    if (!skip) begin
      for (int c = 0; c < NC; c++) begin
        if (c > 0) check("cstart_1cyc_after_done", ctrl_start, 1);
        waited = 0;
        while (ctrl_start !== 1'b1 && waited < 16) begin
          @(negedge clk);
          waited++;
        end
        check("cstart_seen", ctrl_start, 1);
        exp_off = exp_q.pop_front();
        check("ctrl_addr_offset", ctrl_addr_offset, exp_off);
        check("ctrl_xfer_size", ctrl_xfer_size_in_bytes, xfer);
        check("cur_col_load", cur_col, c);
        check("busy_load", busy, 1);
        if (poke_start && c == 0) start = 1'b1;
        d = (done_dly > 0) ? done_dly : $urandom_range(1, 6);
        for (int k = 0; k < d; k++) begin
          @(negedge clk);
          start = 1'b0;
          if (k == 0) check("cstart_one_cycle", ctrl_start, 0);
        end
        ctrl_done = 1'b1;
        @(negedge clk);
        ctrl_done = 1'b0;
      end
    end else begin
      @(negedge clk);
    end

    // PC load cycle
    check("load_PC", load_PC, {NC{1'b1}});
    check("clken_init", clken_PC, {NC{1'b1}});
    check("load_value_PC", load_value_PC, replicate_pc(pc));
    check("incr_init", incr_PC, 0);
    check("cstart_idle_init", ctrl_start, 0);

    issued = 0; run_cycles = 0; stalls_used = 0;
    prev_stall = pick_stall(stall_mode, 1, stalls_used);
    stall = prev_stall;
    while (issued < int'(len) && run_cycles < int'(len) + 16) begin
      @(negedge clk);
      run_cycles++;
      if (prev_stall) stalls_used++;
      check("clken_run", clken_PC, {NC{1'b1}});
      check("load_run", load_PC, 0);
      check("done_run", done, 0);
      check("incr_run", incr_PC, prev_stall ? '0 : {NC{1'b1}});
      if (!prev_stall) issued++;
      check("run_count_run", run_count, issued);
      prev_stall = pick_stall(stall_mode, run_cycles + 1, stalls_used);
      stall = prev_stall;
    end
    if (exp_run_cycles >= 0) check("run_cycles", run_cycles, exp_run_cycles);

    @(negedge clk);
    stall = 1'b0;
    check("done_pulse", done, 1);
    check("busy_done", busy, 0);
    check("clken_done", clken_PC, 0);
    check("incr_done", incr_PC, 0);
    check("run_count_final", run_count, len);
    check("cur_col_final", cur_col, skip ? 0 : NC - 1);
    if (poke_start) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", done, 0);
    check("busy_idle", busy, 0);
    if (poke_start) begin
      @(negedge clk);
      check("start_in_done_ignored", busy, 0);
      check("start_in_done_no_req", ctrl_start, 0);
      check("start_in_done_no_load", load_PC, 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int waited;
    rst_n = 1'b0; start = 1'b0; skip_load = 1'b0; stall = 1'b0; ctrl_done = 1'b0;
    base_addr = '0; col_stride = '0; col_xfer_bytes = '0; start_pc = '0; run_len = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic two-column load, ctrl_done 8 cycles after each request.
    run_job(1'b0, 64'h0, 64'h8, 64'hff, 12'h000, 32'd3, 0, 8, 1'b0, 3);
    // Stall on RUN cycles 2 and 3.
    run_job(1'b0, 64'h1000, 64'h200, 64'h40, 12'h123, 32'd4, 2, 0, 1'b0, 6);
    // skip_load.
    run_job(1'b1, 64'h0, 64'h0, 64'h0, 12'h010, 32'd2, 0, 0, 1'b0, 2);
    // run_len = 0.
    run_job(1'b0, 64'h40, 64'h100, 64'h10, 12'hABC, 32'd0, 0, 0, 1'b0, 0);
    // Start while busy and in the DONE cycle are ignored.
    run_job(1'b0, 64'h80, 64'h20, 64'h20, 12'h7FF, 32'd2, 0, 3, 1'b1, 2);
    // Address wrap: column 1 offset is 0x8.
    run_job(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h10, 64'h100, 12'h001, 32'd1, 0, 0, 1'b0, 1);

    // Stray ctrl_done in IDLE.
    @(negedge clk);
    ctrl_done = 1'b1;
    @(negedge clk);
    ctrl_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stray_done_busy", busy, 0);
      check("stray_done_cstart", ctrl_start, 0);
    end

    // Reset while waiting on column 1.
    @(negedge clk);
    start = 1'b1; skip_load = 1'b0; base_addr = 64'h5000; col_stride = 64'h300;
    col_xfer_bytes = 64'h80; start_pc = 12'h055; run_len = 32'd5;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (ctrl_start !== 1'b1 && waited < 16) begin @(negedge clk); waited++; end
    check("rst_col0_req", ctrl_start, 1);
    repeat (2) @(negedge clk);
    ctrl_done = 1'b1;
    @(negedge clk);
    ctrl_done = 1'b0;
    check("rst_col1_req", ctrl_start, 1);
    check("rst_col1_off", ctrl_addr_offset, 64'h5300);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    ctrl_done = 1'b1;
    @(negedge clk);
    ctrl_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_reset_busy", busy, 0);
      check("post_reset_cstart", ctrl_start, 0);
      check("post_reset_col", cur_col, 0);
    end
    // Fresh job restarts from column 0.
    run_job(1'b0, 64'h5000, 64'h300, 64'h80, 12'h055, 32'd3, 1, 0, 1'b0, -1);

    // Randomized jobs.
    for (int j = 0; j < 8; j++) begin
      run_job(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
              64'($urandom_range(1, 4096)), 12'($urandom), 32'($urandom_range(0, 12)),
              1, 0, 1'($urandom_range(0, 1)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
